// File: rtl/mux_nx1_rr_reg_if.sv
// Handshake bundle for mux_nx1_rr_reg: per-channel producer side plus one
// consumer side. The mux itself uses the slave modport; sources and sinks
// drive the master modport.
interface mux_nx1_rr_reg_if #(
  parameter int W  = 8,
  parameter int CH = 4
);
  localparam int SW = $clog2(CH);

  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid;
  logic            out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_nx1_rr_reg.sv
// N-channel registered multiplexer with valid/ready handshakes.
// Channels are picked either round-robin from a rotating pointer or by a
// fixed index on sel; the chosen word lands in a single output register.
module mux_nx1_rr_reg #(
  parameter int W  = 8,
  parameter int CH = 4,
  localparam int SW = $clog2(CH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  mux_nx1_rr_reg_if.slave bus
);

  logic [W-1:0]  outData_q, outData_d;
  logic [SW-1:0] outCh_q, outCh_d;
  logic          outValid_q, outValid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic [SW-1:0] gnt;
  logic          gntValid;
  logic          accept;
  logic          load;
  logic [CH-1:0] inReady;

  // Grant choice: first valid channel at or after ptr in round-robin mode,
  // or the sel channel in fixed mode (an out-of-range sel grants nothing).
  // The descending loop lets the smallest offset from ptr win.
  always_comb begin
    gnt      = '0;
    gntValid = 1'b0;
    if (mode) begin
      if (int'(sel) < CH) begin
        gnt      = sel;
        gntValid = bus.in_valid[sel];
      end
    end else begin
      for (int k = CH - 1; k >= 0; k--) begin
        if (bus.in_valid[(int'(ptr_q) + k) % CH]) begin
          gnt      = SW'((int'(ptr_q) + k) % CH);
          gntValid = 1'b1;
        end
      end
    end
  end

  assign accept = !reset && en && (!outValid_q || bus.out_ready);
  assign load   = accept && gntValid;

  // Ready goes only to the granted channel, and only when the word will load.
  always_comb begin
    inReady = '0;
    if (load) begin
      inReady[gnt] = 1'b1;
    end
  end

  // Next state: load replaces the held word (even while draining), otherwise
  // a consumed word just clears valid while data and channel stay put.
  always_comb begin
    outData_d  = outData_q;
    outCh_d    = outCh_q;
    outValid_d = outValid_q;
    ptr_d      = ptr_q;
    if (load) begin
      outData_d  = bus.in_data[int'(gnt)*W +: W];
      outCh_d    = gnt;
      outValid_d = 1'b1;
      ptr_d      = (gnt == SW'(CH - 1)) ? '0 : gnt + 1'b1;
    end else if (outValid_q && bus.out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer, cleared immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outData_q  <= '0;
      outCh_q    <= '0;
      outValid_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      outData_q  <= outData_d;
      outCh_q    <= outCh_d;
      outValid_q <= outValid_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_data  = outData_q;
  assign bus.out_ch    = outCh_q;
  assign bus.out_valid = outValid_q;

endmodule
